layer_sched: RTL

- Pass-level scheduler for the conv/pool pixel engine.
- Latches a layer configuration on start and walks every (col,row) of the feature map with a req/ack pixel handshake.
- Runs a conv pass (c_p=0), then an optional pool pass (c_p=1), then pulses done.
- Includes a per-pixel watchdog and an abort path; sits between the host/config logic and the pixel-level control FSM.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/pix_walker.sv | 53 +++++
 rtl/layer_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv/pool scheduling blocks.
package cnn_pkg;

  localparam int unsigned DIM_W_DEF = 4;

  localparam logic C_P_CONV = 1'b0;
  localparam logic C_P_POOL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_CONV = 2'd1,
    ST_RUN_POOL = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/pix_walker.sv
// Column/row raster counter over a latched feature-map extent.
module pix_walker
  import cnn_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic             clear,
  input  logic             advance,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last_pix
);

  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;

  // Advancing past the last pixel wraps to (0,0), ready for the next pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      h_q <= '0;
      col <= '0;
      row <= '0;
    end else if (load) begin
      w_q <= cfg_w;
      h_q <= cfg_h;
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col != w_q) begin
        col <= col + DIM_W'(1);
      end else begin
        col <= '0;
        if (row != h_q) begin
          row <= row + DIM_W'(1);
        end else begin
          row <= '0;
        end
      end
    end
  end

  assign last_pix = (col == w_q) && (row == h_q);

endmodule

// File: rtl/layer_sched.sv
// Pass-level scheduler: conv pass, optional pool pass, per-pixel watchdog and abort.
module layer_sched
  import cnn_pkg::*;
#(
  parameter int unsigned DIM_W   = DIM_W_DEF,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic             cfg_pool,
  output logic             pix_req,
  input  logic             pix_ack,
  output logic             c_p,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

  sched_state_t    state_q, state_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            pool_q, pool_d;
  logic            err_d;
  logic            walk_load, walk_clear, walk_adv;
  logic            last_pix;
  logic            run_d;

  pix_walker #(.DIM_W(DIM_W)) u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (walk_load),
    .cfg_w    (cfg_w),
    .cfg_h    (cfg_h),
    .clear    (walk_clear),
    .advance  (walk_adv),
    .col      (col),
    .row      (row),
    .last_pix (last_pix)
  );

  // Priority inside a pass: abort, then ack, then watchdog expiry.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    pool_d     = pool_q;
    err_d      = err;
    walk_load  = 1'b0;
    walk_clear = 1'b0;
    walk_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          walk_load = 1'b1;
          pool_d    = cfg_pool;
          err_d     = 1'b0;
          wdog_d    = '0;
          state_d   = ST_RUN_CONV;
        end
      end
      ST_RUN_CONV, ST_RUN_POOL: begin
        if (abort) begin
          walk_clear = 1'b1;
          wdog_d     = '0;
          state_d    = ST_IDLE;
        end else if (pix_ack) begin
          walk_adv = 1'b1;
          wdog_d   = '0;
          if (last_pix) begin
            state_d = (state_q == ST_RUN_CONV && pool_q) ? ST_RUN_POOL : ST_DONE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          walk_clear = 1'b1;
          wdog_d     = '0;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wdog_d = wdog_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run_d = (state_d == ST_RUN_CONV) || (state_d == ST_RUN_POOL);

  // Outputs are registered from the next-state decode so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      pool_q  <= 1'b0;
      pix_req <= 1'b0;
      busy    <= 1'b0;
      c_p     <= C_P_CONV;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      pool_q  <= pool_d;
      pix_req <= run_d;
      busy    <= run_d;
      c_p     <= (state_d == ST_RUN_POOL) ? C_P_POOL : C_P_CONV;
      done    <= (state_d == ST_DONE);
      err     <= err_d;
    end
  end

endmodule
